// File: rtl/pad_cfg_loader.sv
// pad_cfg_loader: serial configuration loader for the pad-control mux tree.
//
// Write frame: cmd=1, 13 data bits MSB first ({test_ctl, port_ctl}), even-parity bit,
// then cfg_sel low. The config outputs load atomically on the edge that first samples
// cfg_sel low, and only if the frame was exactly 15 bits with correct parity.
// Read frame: cmd=0; the current {test_ctl, port_ctl, parity} is shifted out on cfg_sdo.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   cfg_sel       frame enable (high for the whole frame)
//   cfg_sdi       serial data in
//   cfg_sdo       serial data out (registered, read frames only)
//   cfg_busy      frame in progress
//   cfg_done      one-cycle pulse: frame completed
//   cfg_err       one-cycle pulse: frame aborted/short/overrun/parity error
//   test_ctl_out  registered test_ctl to chip_top
//   port_ctl_out  registered port_ctl to chip_top
module pad_cfg_loader #(
    parameter int unsigned          TEST_W   = 6,
    parameter int unsigned          PORT_W   = 7,
    parameter logic [TEST_W-1:0]    TEST_RST = 6'h20,
    parameter logic [PORT_W-1:0]    PORT_RST = 7'h60
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_sel,
    input  logic              cfg_sdi,
    output logic              cfg_sdo,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [TEST_W-1:0] test_ctl_out,
    output logic [PORT_W-1:0] port_ctl_out
);

    localparam int unsigned CFG_W    = TEST_W + PORT_W;
    // Counter value on the edge that shifts the last data bit (write) / last read bit.
    localparam logic [3:0]  LastData = 4'(CFG_W - 1);
    localparam logic [3:0]  LastRead = 4'(CFG_W);

    // StCmd is never entered: the command bit is decoded directly in StIdle.
    typedef enum logic [2:0] {
        StIdle, StCmd, StWdata, StWpar, StWhold, StRdata, StRtail
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [CFG_W-1:0]   shadow_q, shadow_d;
    logic [CFG_W-1:0]   shift_q, shift_d;
    logic               par_q, par_d;
    logic               ovr_q, ovr_d;
    logic               sdo_q, sdo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [TEST_W-1:0]  test_q, test_d;
    logic [PORT_W-1:0]  port_q, port_d;
    logic [3:0]         cnt_inc;

    // Saturating bit counter: never wraps back into a valid count.
    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        shift_d  = shift_q;
        par_d    = par_q;
        ovr_d    = ovr_q;
        sdo_d    = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        test_d   = test_q;
        port_d   = port_q;

        case (state_q)
            StIdle: begin
                if (cfg_sel) begin
                    busy_d = 1'b1;
                    cnt_d  = 4'd0;
                    ovr_d  = 1'b0;
                    if (cfg_sdi) begin
                        state_d = StWdata;
                    end else begin
                        state_d = StRdata;
                        // MSB goes straight to cfg_sdo; the rest waits in the shifter.
                        {sdo_d, shift_d} = {test_q, port_q, ^{test_q, port_q}};
                    end
                end
            end
            StWdata: begin
                if (!cfg_sel) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    shadow_d = {shadow_q[CFG_W-2:0], cfg_sdi};
                    cnt_d    = cnt_inc;
                    if (cnt_q == LastData) begin
                        state_d = StWpar;
                    end
                end
            end
            StWpar: begin
                if (!cfg_sel) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    par_d   = cfg_sdi;
                    state_d = StWhold;
                end
            end
            StWhold: begin
                if (cfg_sel) begin
                    ovr_d = 1'b1;
                end else begin
                    if (!ovr_q && !(^{shadow_q, par_q})) begin
                        test_d = shadow_q[CFG_W-1:PORT_W];
                        port_d = shadow_q[PORT_W-1:0];
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            StRdata: begin
                if (!cfg_sel) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q == LastRead) begin
                        state_d = StRtail;
                    end else begin
                        {sdo_d, shift_d} = {shift_q, 1'b0};
                    end
                end
            end
            StRtail: begin
                if (!cfg_sel) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            shadow_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            ovr_q    <= 1'b0;
            sdo_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            test_q   <= TEST_RST;
            port_q   <= PORT_RST;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            ovr_q    <= ovr_d;
            sdo_q    <= sdo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            test_q   <= test_d;
            port_q   <= port_d;
        end
    end

    assign cfg_sdo      = sdo_q;
    assign cfg_busy     = busy_q;
    assign cfg_done     = done_q;
    assign cfg_err      = err_q;
    assign test_ctl_out = test_q;
    assign port_ctl_out = port_q;

endmodule

// File: tb/tb_pad_cfg_loader.sv
// Bench for pad_cfg_loader: directed frames followed by random frames, checked every
// cycle against a frame-level model (frame length, parity, stored configuration).
module tb_pad_cfg_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_sel;
    logic       cfg_sdi;
    logic       cfg_sdo;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_err;
    logic [5:0] test_ctl_out;
    logic [6:0] port_ctl_out;

    int total = 0;
    int bad   = 0;

    // Model of the stored configuration.
    logic [5:0] m_test;
    logic [6:0] m_port;

    pad_cfg_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_sel      (cfg_sel),
        .cfg_sdi      (cfg_sdi),
        .cfg_sdo      (cfg_sdo),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .test_ctl_out (test_ctl_out),
        .port_ctl_out (port_ctl_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame bit i of the returned vector is the i-th bit on the wire.
    function automatic logic [31:0] mk_write(input logic [12:0] data, input logic par);
        logic [31:0] f;
        f    = '0;
        f[0] = 1'b1;
        for (int j = 0; j < 13; j++) f[1+j] = data[12-j];
        f[14] = par;
        return f;
    endfunction

    // Drives n bits with cfg_sel high, then one edge with cfg_sel low; checks every cycle.
    task automatic run_frame(input logic [31:0] frm, input int n);
        logic [13:0] word;
        logic [12:0] data;
        logic        cmd;
        logic        ok;
        logic        exp_sdo;
        cmd  = frm[0];
        word = {m_test, m_port, ^{m_test, m_port}};
        for (int j = 0; j < 13; j++) data[12-j] = frm[1+j];
        for (int k = 0; k <= n; k++) begin
            cfg_sel = (k < n);
            cfg_sdi = (k < n) ? frm[k] : 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (k < n) begin
                exp_sdo = (!cmd && k <= 13) ? word[13-k] : 1'b0;
                check("busy_mid", cfg_busy, 1);
                check("done_mid", cfg_done, 0);
                check("err_mid", cfg_err, 0);
                check("sdo_mid", cfg_sdo, exp_sdo);
            end else begin
                ok = cmd ? (n == 15 && (^data ^ frm[14]) == 1'b0) : (n >= 15);
                if (ok && cmd) begin
                    m_test = data[12:7];
                    m_port = data[6:0];
                end
                check("busy_end", cfg_busy, 0);
                check("sdo_end", cfg_sdo, 0);
                check("done_end", cfg_done, ok);
                check("err_end", cfg_err, !ok);
            end
            check("test_ctl", test_ctl_out, m_test);
            check("port_ctl", port_ctl_out, m_port);
        end
    endtask

    initial begin
        logic [31:0] f;
        logic [12:0] d;
        logic        p;
        int          n;

        // Reset state.
        rst_n   = 1'b0;
        cfg_sel = 1'b0;
        cfg_sdi = 1'b0;
        m_test  = 6'h20;
        m_port  = 7'h60;
        repeat (2) @(negedge clk);
        check("rst_test", test_ctl_out, 6'h20);
        check("rst_port", port_ctl_out, 7'h60);
        check("rst_sdo", cfg_sdo, 0);
        check("rst_busy", cfg_busy, 0);
        check("rst_done", cfg_done, 0);
        check("rst_err", cfg_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Bad parity, 16-bit overrun, early drop after 8 data bits: all rejected.
        run_frame(mk_write(13'h0AAA, 1'b1), 15);
        run_frame(mk_write(13'h0AAA, 1'b0), 16);
        run_frame(mk_write(13'h0AAA, 1'b0), 9);
        check("no_upd_test", test_ctl_out, 6'h20);
        check("no_upd_port", port_ctl_out, 7'h60);

        // Legal write of 0xAAA.
        run_frame(mk_write(13'h0AAA, 1'b0), 15);
        check("wr_aaa_test", test_ctl_out, 6'h15);
        check("wr_aaa_port", port_ctl_out, 7'h2A);

        // Read with cfg_sel held 16 cycles, then a short read and a long hold.
        run_frame(32'h0, 16);
        run_frame(32'hFFFF_FFFE, 14);
        run_frame(32'h0, 28);

        // Overrun held long in the hold state, then back-to-back legal writes.
        run_frame(mk_write(13'h1F0F, ^13'h1F0F) | 32'hFFFF_8000, 30);
        run_frame(mk_write(13'h1234, ^13'h1234), 15);
        run_frame(mk_write(13'h0ACE, ^13'h0ACE), 15);
        run_frame(32'h0, 15);

        // Random frames.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                d = 13'($urandom);
                p = ^d ^ ($urandom_range(0, 3) == 0);
                n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 15;
                f = mk_write(d, p);
                f[31:15] = 17'($urandom);
            end else begin
                f    = $urandom;
                f[0] = 1'b0;
                n    = int'($urandom_range(1, 24));
            end
            run_frame(f, n);
        end

        // Make sure the config differs from reset, then reset mid-write.
        run_frame(mk_write(13'h0555, ^13'h0555), 15);
        f       = mk_write(13'h1FFF, ^13'h1FFF);
        cfg_sel = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cfg_sdi = f[k];
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_test", test_ctl_out, 6'h20);
        check("mid_rst_port", port_ctl_out, 7'h60);
        check("mid_rst_busy", cfg_busy, 0);
        check("mid_rst_sdo", cfg_sdo, 0);
        cfg_sel = 1'b0;
        m_test  = 6'h20;
        m_port  = 7'h60;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(mk_write(13'h0AAA, 1'b0), 15);
        run_frame(32'h0, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
